vga_pixel_gen: RTL and testbench
================================

VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 Parameter BALL_COLOR, default 8'hFC, SHALL be the RGB332 colour of the moving square.
REQ-002 Parameter BG_COLOR, default 8'h03, SHALL be the RGB332 colour of the visible interior background.
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset: reset=0 at a rising clk edge resets the block.
REQ-005 p_tick  input  1  SHALL be the one-clk-wide pixel enable from the sync generator.
REQ-006 video_on  input  1  SHALL mark the current pixel as lying in the 640x480 visible area.
REQ-007 hsync_in, vsync_in  input  1 each  SHALL be the raw sync signals from the sync generator.
REQ-008 pixel_x, pixel_y  input  10 each  SHALL be the current pixel coordinates.
REQ-009 color_sel  input  3  SHALL select the border colour.
REQ-010 pause  input  1  SHALL freeze square motion when set to 1.
REQ-011 hsync, vsync  output  1 each  SHALL be the sync signals, delayed to align with rgb.
REQ-012 rgb  output  8  SHALL be the RGB332 pixel colour.
REQ-013 frame_tick  output  1  SHALL be the one-clk end-of-frame pulse.

Function
REQ-014 frame_tick SHALL be 1 for exactly the clk in which p_tick=1, pixel_x=0 and pixel_y=480; it SHALL be 0 at all other times (combinational decode, not registered).
REQ-015 Square state SHALL be ball_x and ball_y (10 bits each, top-left corner, 16x16 size) plus direction bits dir_x and dir_y (1 = increasing).
REQ-016 Square state SHALL update only in a clk where frame_tick=1, pause=0 and reset=1.
REQ-017 X update when dir_x=1: if ball_x>=614, set ball_x=616 and dir_x=0; otherwise ball_x+=2.
REQ-018 X update when dir_x=0: if ball_x<=10, set ball_x=8 and dir_x=1; otherwise ball_x-=2.
REQ-019 Y update SHALL follow the same rules with limits 454/456 (upper) and 10/8 (lower).
REQ-020 Border region SHALL be pixel_x<8, pixel_x>=632, pixel_y<8 or pixel_y>=472, within the visible area.
REQ-021 Square region SHALL be ball_x<=pixel_x<ball_x+16 and ball_y<=pixel_y<ball_y+16.
REQ-022 Pipeline stage 1 SHALL register, on each p_tick, the square hit, border hit, video_on, hsync_in and vsync_in.
REQ-023 Pipeline stage 2 SHALL register, on each p_tick, rgb, hsync and vsync from the stage-1 values; total latency SHALL be 2 p_ticks.
REQ-024 Colour priority SHALL be: video_on=0 gives 8'h00; else square gives BALL_COLOR; else border gives the palette entry; else BG_COLOR.
REQ-025 Palette by color_sel 0..7 SHALL be FF, E0, 1C, 03, FC, 1F, E3, 92; color_sel SHALL be sampled in stage 1.
REQ-026 Pipeline registers SHALL hold their values in clks where p_tick=0.
REQ-027 Square state updates SHALL occur only during vertical blank (pixel_y=480), so a visible frame never tears.

Reset
REQ-028 While reset=0, the following SHALL hold, with reset overriding p_tick, frame_tick and pause: rgb=8'h00, hsync=0, vsync=0, all pipeline registers cleared, ball_x=320, ball_y=240, dir_x=1, dir_y=1.
REQ-029 frame_tick SHALL be forced to 0 while reset=0.
REQ-030 Reset asserted mid-frame SHALL take effect at the next clk edge, with no partial pipeline output afterwards.

Verification
REQ-031 Reset scenario: hold reset=0 for 5 clks with p_tick toggling -> rgb=00, hsync=vsync=0, frame_tick=0, square at (320,240).
REQ-032 Border scenario: video_on=1, pixel (0,0), color_sel=1 -> rgb=E0 exactly 2 p_ticks later; with color_sel=6 -> E3.
REQ-033 Square/background scenario: pixel (330,250) -> FC; pixel (100,100) -> 03; video_on=0 at pixel (330,250) -> 00; hsync_in/vsync_in pulses appear on hsync/vsync 2 p_ticks later.
REQ-034 Bounce scenario: from reset, apply 147 frame_ticks -> ball_x=614; 148 -> ball_x=616, dir_x=0; 149 -> ball_x=614. Also 107 frame_ticks -> ball_y=454; 108 -> ball_y=456, dir_y=0; 109 -> ball_y=454.
REQ-035 Pause scenario: pause=1 across 3 frame_ticks -> position unchanged; release pause -> the next frame_tick moves the square by 2 in each axis.
REQ-036 Mid-operation reset scenario: reset=0 for one clk after 50 frame_ticks -> square at (320,240), dir=1/1, rgb=00 on the next clk.

Source files
------------

// File: rtl/vga_pixel_gen.sv
// Pixel colour generator: a 16x16 square bouncing off a coloured border, with
// a two-stage pipeline on p_tick that delays hsync/vsync to stay aligned with rgb.
module vga_pixel_gen #(
  parameter logic [7:0] BALL_COLOR = 8'hFC,
  parameter logic [7:0] BG_COLOR   = 8'h03
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [2:0] color_sel,
  input  logic       pause,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_tick
);
  logic [9:0]  r_ball_x, r_ball_y;
  logic        r_dir_x, r_dir_y;
  logic [10:0] w_step_x, w_step_y;
  logic        w_sq_hit, w_bd_hit;

  logic        r_sq_p1, r_bd_p1, r_von_p1, r_hs_p1, r_vs_p1;
  logic [2:0]  r_csel_p1;
  logic [7:0]  r_rgb_p2;
  logic        r_hs_p2, r_vs_p2;

  // Returns {next_dir, next_pos}; the low wall sits at 8 for both axes.
  function automatic logic [10:0] ball_step(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] hi_lim);
    logic [10:0] r;
    if (dir) begin
      if (pos >= hi_lim - 10'd2) r = {1'b0, hi_lim};
      else                       r = {1'b1, pos + 10'd2};
    end else begin
      if (pos <= 10'd10) r = {1'b1, 10'd8};
      else               r = {1'b0, pos - 10'd2};
    end
    return r;
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] sel);
    logic [7:0] c;
    case (sel)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hE0;
      3'd2:    c = 8'h1C;
      3'd3:    c = 8'h03;
      3'd4:    c = 8'hFC;
      3'd5:    c = 8'h1F;
      3'd6:    c = 8'hE3;
      default: c = 8'h92;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] pix_color(input logic von, input logic sq,
                                           input logic bd, input logic [2:0] sel);
    logic [7:0] c;
    if (!von)    c = 8'h00;
    else if (sq) c = BALL_COLOR;
    else if (bd) c = palette(sel);
    else         c = BG_COLOR;
    return c;
  endfunction

  // Frame boundary sits in vertical blank, so moving the square here never tears.
  assign frame_tick = reset & p_tick & (pixel_x == 10'd0) & (pixel_y == 10'd480);

  assign w_step_x = ball_step(r_ball_x, r_dir_x, 10'd616);
  assign w_step_y = ball_step(r_ball_y, r_dir_y, 10'd456);

  assign w_sq_hit = ({1'b0, pixel_x} >= {1'b0, r_ball_x}) &&
                    ({1'b0, pixel_x} <  {1'b0, r_ball_x} + 11'd16) &&
                    ({1'b0, pixel_y} >= {1'b0, r_ball_y}) &&
                    ({1'b0, pixel_y} <  {1'b0, r_ball_y} + 11'd16);
  assign w_bd_hit = (pixel_x < 10'd8) || (pixel_x >= 10'd632) ||
                    (pixel_y < 10'd8) || (pixel_y >= 10'd472);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ball_x <= 10'd320;
      r_ball_y <= 10'd240;
      r_dir_x  <= 1'b1;
      r_dir_y  <= 1'b1;
    end else if (frame_tick && !pause) begin
      {r_dir_x, r_ball_x} <= w_step_x;
      {r_dir_y, r_ball_y} <= w_step_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sq_p1   <= 1'b0;
      r_bd_p1   <= 1'b0;
      r_von_p1  <= 1'b0;
      r_hs_p1   <= 1'b0;
      r_vs_p1   <= 1'b0;
      r_csel_p1 <= 3'd0;
      r_rgb_p2  <= 8'h00;
      r_hs_p2   <= 1'b0;
      r_vs_p2   <= 1'b0;
    end else if (p_tick) begin
      // stage 1: region hits and sync capture
      r_sq_p1   <= w_sq_hit;
      r_bd_p1   <= w_bd_hit;
      r_von_p1  <= video_on;
      r_hs_p1   <= hsync_in;
      r_vs_p1   <= vsync_in;
      r_csel_p1 <= color_sel;
      // stage 2: colour resolve
      r_rgb_p2  <= pix_color(r_von_p1, r_sq_p1, r_bd_p1, r_csel_p1);
      r_hs_p2   <= r_hs_p1;
      r_vs_p2   <= r_vs_p1;
    end
  end

  assign rgb   = r_rgb_p2;
  assign hsync = r_hs_p2;
  assign vsync = r_vs_p2;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: directed scenarios plus randomized cycles checked
// against a behavioural model of the square motion and colour pipeline.
module tb_vga_pixel_gen;
  logic       clk = 1'b0;
  logic       reset, p_tick, video_on, hsync_in, vsync_in, pause;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] color_sel;
  logic       hsync, vsync, frame_tick;
  logic [7:0] rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_gen dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .color_sel(color_sel), .pause(pause), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_tick(frame_tick)
  );

  logic [7:0] pal [8] = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h92};

  // Reference state: square position/direction, one pending pixel, and outputs.
  int         m_bx, m_by;
  bit         m_dx, m_dy;
  bit         s_sq, s_bd, s_von, s_hs, s_vs;
  int         s_cs;
  logic [7:0] m_rgb;
  bit         m_hs, m_vs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1;
    s_sq = 0; s_bd = 0; s_von = 0; s_hs = 0; s_vs = 0; s_cs = 0;
    m_rgb = 8'h00; m_hs = 0; m_vs = 0;
  endtask

  task automatic cyc(input bit rst_n, input bit pt, input bit von, input bit hs, input bit vs,
                     input int px, input int py, input int cs, input bit pa);
    bit ft;
    reset = rst_n; p_tick = pt; video_on = von; hsync_in = hs; vsync_in = vs;
    pixel_x = px[9:0]; pixel_y = py[9:0]; color_sel = cs[2:0]; pause = pa;
    #1;
    ft = rst_n && pt && (px == 0) && (py == 480);
    check("frame_tick", 32'(frame_tick), 32'(ft));
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else if (pt) begin
      m_rgb = !s_von ? 8'h00 : s_sq ? 8'hFC : s_bd ? pal[s_cs] : 8'h03;
      m_hs = s_hs; m_vs = s_vs;
      s_sq  = (px >= m_bx) && (px < m_bx + 16) && (py >= m_by) && (py < m_by + 16);
      s_bd  = (px < 8) || (px >= 632) || (py < 8) || (py >= 472);
      s_von = von; s_hs = hs; s_vs = vs; s_cs = cs;
      if (ft && !pa) begin
        if (m_dx) begin if (m_bx >= 614) begin m_bx = 616; m_dx = 0; end else m_bx += 2; end
        else      begin if (m_bx <= 10)  begin m_bx = 8;   m_dx = 1; end else m_bx -= 2; end
        if (m_dy) begin if (m_by >= 454) begin m_by = 456; m_dy = 0; end else m_by += 2; end
        else      begin if (m_by <= 10)  begin m_by = 8;   m_dy = 1; end else m_by -= 2; end
      end
    end
    check("rgb",   32'(rgb),   32'(m_rgb));
    check("hsync", 32'(hsync), 32'(m_hs));
    check("vsync", 32'(vsync), 32'(m_vs));
    check("ball_x", 32'(dut.r_ball_x), 32'(m_bx));
    check("ball_y", 32'(dut.r_ball_y), 32'(m_by));
    check("dir_x", 32'(dut.r_dir_x), 32'(m_dx));
    check("dir_y", 32'(dut.r_dir_y), 32'(m_dy));
  endtask

  // Present one pixel, idle a clk, then push it through with a neutral pixel.
  task automatic probe(input string tag, input bit von, input bit hs, input bit vs,
                       input int px, input int py, input int cs,
                       input logic [7:0] e_rgb, input bit e_hs, input bit e_vs);
    cyc(1, 1, von, hs, vs, px, py, cs, 0);
    cyc(1, 0, 0, 0, 0, px, py, cs, 0);
    cyc(1, 1, 0, 0, 0, 100, 100, 0, 0);
    check({tag, "_rgb"},   32'(rgb),   32'(e_rgb));
    check({tag, "_hsync"}, 32'(hsync), 32'(e_hs));
    check({tag, "_vsync"}, 32'(vsync), 32'(e_vs));
  endtask

  task automatic frame_ticks(input int n, input bit pa);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 480, 0, pa);
  endtask

  initial begin
    model_reset();
    // reset held for 5 clks with p_tick toggling, sitting on the frame-tick pixel
    for (int k = 0; k < 5; k++) cyc(0, (k % 2) == 0, 1, 1, 1, 0, 480, 1, 0);
    check("rst_rgb", 32'(rgb), 32'h00);
    check("rst_hsync", 32'(hsync), 32'h0);
    check("rst_vsync", 32'(vsync), 32'h0);
    check("rst_ftick", 32'(frame_tick), 32'h0);
    check("rst_ball_x", 32'(dut.r_ball_x), 32'd320);
    check("rst_ball_y", 32'(dut.r_ball_y), 32'd240);

    probe("border_cs1", 1, 0, 0, 0, 0, 1, 8'hE0, 0, 0);
    probe("border_cs6", 1, 0, 0, 0, 0, 6, 8'hE3, 0, 0);
    probe("square",     1, 0, 0, 330, 250, 3, 8'hFC, 0, 0);
    probe("bg",         1, 0, 0, 100, 100, 3, 8'h03, 0, 0);
    probe("blank",      0, 0, 0, 330, 250, 3, 8'h00, 0, 0);
    probe("sync",       1, 1, 1, 100, 100, 0, 8'h03, 1, 1);

    // bounce off the far walls
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 149; n++) begin
      frame_ticks(1, 0);
      if (n == 107) check("by_107", 32'(dut.r_ball_y), 32'd454);
      if (n == 108) begin
        check("by_108", 32'(dut.r_ball_y), 32'd456);
        check("dy_108", 32'(dut.r_dir_y), 32'd0);
      end
      if (n == 109) check("by_109", 32'(dut.r_ball_y), 32'd454);
      if (n == 147) check("bx_147", 32'(dut.r_ball_x), 32'd614);
      if (n == 148) begin
        check("bx_148", 32'(dut.r_ball_x), 32'd616);
        check("dx_148", 32'(dut.r_dir_x), 32'd0);
      end
      if (n == 149) check("bx_149", 32'(dut.r_ball_x), 32'd614);
    end

    // pause freezes motion; release moves one step in each axis
    frame_ticks(3, 1);
    check("pause_x", 32'(dut.r_ball_x), 32'd614);
    check("pause_y", 32'(dut.r_ball_y), 32'd374);
    frame_ticks(1, 0);
    check("resume_x", 32'(dut.r_ball_x), 32'd612);
    check("resume_y", 32'(dut.r_ball_y), 32'd372);

    // reset in mid-operation with a square pixel in flight
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame_ticks(50, 0);
    cyc(1, 1, 1, 1, 1, 425, 345, 0, 0);
    cyc(1, 1, 1, 1, 1, 425, 345, 0, 0);
    check("pre_rst_rgb", 32'(rgb), 32'hFC);
    cyc(0, 1, 1, 1, 1, 425, 345, 0, 0);
    check("mid_rst_rgb", 32'(rgb), 32'h00);
    check("mid_rst_hsync", 32'(hsync), 32'h0);
    check("mid_rst_x", 32'(dut.r_ball_x), 32'd320);
    check("mid_rst_y", 32'(dut.r_ball_y), 32'd240);
    check("mid_rst_dx", 32'(dut.r_dir_x), 32'd1);
    check("mid_rst_dy", 32'(dut.r_dir_y), 32'd1);
    cyc(1, 0, 1, 1, 1, 425, 345, 0, 0);
    check("post_rst_rgb", 32'(rgb), 32'h00);

    // randomized traffic, biased toward the square and the frame-tick pixel
    for (int i = 0; i < 3000; i++) begin
      bit r_n, pt, von, hs, vs, pa;
      int px, py, cs;
      r_n = ($urandom_range(0, 199) != 0);
      pt  = ($urandom_range(0, 2) != 0);
      von = ($urandom_range(0, 3) != 0);
      hs  = $urandom_range(0, 1) == 1;
      vs  = $urandom_range(0, 1) == 1;
      pa  = ($urandom_range(0, 3) == 0);
      cs  = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) begin
        px = 0; py = 480;
      end else if ($urandom_range(0, 2) == 0) begin
        px = m_bx + $urandom_range(0, 23) - 4;
        py = m_by + $urandom_range(0, 23) - 4;
      end else begin
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 524);
      end
      cyc(r_n, pt, von, hs, vs, px, py, cs, pa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
